multi_pulse_filter: RTL and testbench
=====================================

MULTI_PULSE_FILTER -- requirements
Module: multi_pulse_filter

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent filter channels, range 1..32.
REQ-002 SHALL have parameter FILTER_LEN, default 3: consecutive differing samples needed to change filtered level, range 1..255.
REQ-003 SHALL have parameter CNT_W, default 8: width of each per-channel glitch counter, range 1..16.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port en  input  1  global sample enable.
REQ-008 SHALL have port clr_glitch  input  1  clears all glitch counters.
REQ-009 SHALL have port noisy_in  input  CHANNELS  raw per-channel inputs, synchronous to clk.
REQ-010 SHALL have port level_out  output  CHANNELS  registered filtered level per channel.
REQ-011 SHALL have port rise_pulse  output  CHANNELS  one-cycle strobe on filtered 0->1.
REQ-012 SHALL have port fall_pulse  output  CHANNELS  one-cycle strobe on filtered 1->0.
REQ-013 SHALL have port glitch_cnt  output  CHANNELS*CNT_W  per-channel saturating glitch count; channel i at bits [i*CNT_W +: CNT_W].

Function
REQ-014 SHALL give each channel a run counter of width $clog2(FILTER_LEN+1), plus level and glitch registers; channels are fully independent.
REQ-015 SHALL, when en=1 and noisy_in[i] != level_out[i] and run counter < FILTER_LEN-1, increment the run counter.
REQ-016 SHALL, when en=1 and noisy_in[i] != level_out[i] and run counter == FILTER_LEN-1, toggle level_out[i], clear the run counter, and assert the matching rise_pulse[i]/fall_pulse[i] in the same cycle as the level change.
REQ-017 SHALL give latency of FILTER_LEN edges from the first differing sample to the level_out change; FILTER_LEN=1 gives a 1-edge change.
REQ-018 SHALL, when en=1 and noisy_in[i] == level_out[i] and run counter != 0, clear the run counter and increment glitch_cnt[i] (an aborted run counts as one glitch).
REQ-019 SHALL saturate glitch_cnt[i] at 2^CNT_W-1; no wrap-around.
REQ-020 SHALL, when en=0, hold run counters, levels and glitch counts, drive rise_pulse=fall_pulse=0, and resume counting from the held value when en returns to 1.
REQ-021 SHALL, when clr_glitch=1, clear all glitch counters regardless of en; clear wins over a simultaneous increment.
REQ-022 SHALL keep rise_pulse and fall_pulse one cycle wide; per channel they are never both 1; a constant input produces no further pulses.
REQ-023 SHALL let the level change after exactly FILTER_LEN differing samples even if the next sample reverts; that reversal starts a new run and does not count as a glitch.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, clear level_out, rise_pulse, fall_pulse, all run counters and all glitch_cnt to 0; rst has priority over en and clr_glitch.
REQ-025 SHALL have rst mid-run discard partial runs without counting a glitch; the first post-reset sample starts a fresh run.

Verification
REQ-026 SHALL cover: defaults, reset, noisy_in[0]=1 held -> level_out[0]=1 and rise_pulse[0]=1 after the 3rd edge, pulse low on the 4th edge, other channels unchanged.
REQ-027 SHALL cover: level_out[1]=0, noisy_in[1]=1 for 2 cycles then 0 -> level_out[1] stays 0, glitch_cnt[1]=1 after the reverting edge.
REQ-028 SHALL cover: level_out[2]=1, noisy_in[2]=0 for 1 cycle, en=0 for 4 cycles, then 0 for 2 cycles with en=1 -> fall_pulse[2]=1 on the 2nd enabled edge, no glitch counted.
REQ-029 SHALL cover: CNT_W=2, 5 aborted runs on ch3 -> glitch_cnt[3]=3 (saturated); clr_glitch coincident with a 6th glitch -> 0.
REQ-030 SHALL cover: FILTER_LEN=1, alternating input every cycle -> level follows with 1-edge lag, alternating rise/fall pulses, glitch_cnt=0.
REQ-031 SHALL cover: rst=1 asserted with run counter at 2 on ch0 -> all outputs 0 next edge; then 3 high samples are needed for rise_pulse[0].

Source files
------------

// File: rtl/multi_pulse_filter.sv
// multi_pulse_filter
//   Multi-channel digital deglitcher. Each channel keeps a filtered level that
//   changes only after FILTER_LEN consecutive enabled samples disagree with it.
//   When a level changes, a one-cycle rise or fall strobe is issued. A run of
//   disagreeing samples that ends before the threshold counts as one glitch.
//   Each channel has its own saturating glitch counter.
//
// Parameters
//   CHANNELS   : number of independent channels (1..32)
//   FILTER_LEN : consecutive differing samples needed to change level (1..255)
//   CNT_W      : width of each glitch counter (1..16)
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   rst        : synchronous active-high reset, highest priority
//   en         : global sample enable; when low, all state holds and strobes stay 0
//   clr_glitch : clears every glitch counter; takes priority over an increment
//   noisy_in   : raw per-channel inputs, synchronous to clk
//   level_out  : registered filtered level per channel
//   rise_pulse : one-cycle strobe on a filtered 0->1 change
//   fall_pulse : one-cycle strobe on a filtered 1->0 change
//   glitch_cnt : packed glitch counters, channel i at [i*CNT_W +: CNT_W]
module multi_pulse_filter #(
    parameter int CHANNELS   = 4,
    parameter int FILTER_LEN = 3,
    parameter int CNT_W      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      clr_glitch,
    input  logic [CHANNELS-1:0]       noisy_in,
    output logic [CHANNELS-1:0]       level_out,
    output logic [CHANNELS-1:0]       rise_pulse,
    output logic [CHANNELS-1:0]       fall_pulse,
    output logic [CHANNELS*CNT_W-1:0] glitch_cnt
);

    localparam int RUN_W = $clog2(FILTER_LEN + 1);
    // Run count on the sample that completes the run; that sample flips the
    // level instead of incrementing, so the counter never reaches FILTER_LEN.
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILTER_LEN - 1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [RUN_W-1:0] run_q;
        logic [CNT_W-1:0] glitch_q;
        logic             level_q;
        logic             rise_q;
        logic             fall_q;
        logic             differ;

        assign differ = noisy_in[i] ^ level_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                run_q    <= '0;
                glitch_q <= '0;
                level_q  <= 1'b0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (en) begin
                    if (differ) begin
                        if (run_q == RUN_LAST) begin
                            // Run complete: flip level and strobe in the same
                            // edge. The next sample starts a fresh run, so an
                            // immediate reversal is never a glitch.
                            run_q   <= '0;
                            level_q <= ~level_q;
                            rise_q  <= ~level_q;
                            fall_q  <= level_q;
                        end else begin
                            run_q <= run_q + 1'b1;
                        end
                    end else if (run_q != '0) begin
                        // Aborted run: input fell back to the current level.
                        run_q <= '0;
                        if (glitch_q != {CNT_W{1'b1}}) begin
                            glitch_q <= glitch_q + 1'b1;
                        end
                    end
                end
                // Placed last so a clear overrides an increment in the same cycle.
                if (clr_glitch) begin
                    glitch_q <= '0;
                end
            end
        end

        assign level_out[i]                   = level_q;
        assign rise_pulse[i]                  = rise_q;
        assign fall_pulse[i]                  = fall_q;
        assign glitch_cnt[i*CNT_W +: CNT_W]   = glitch_q;
    end

endmodule

// File: tb/tb_multi_pulse_filter.sv
// tb_multi_pulse_filter
//   Three instances share one stimulus stream: default parameters, CNT_W=2
//   (glitch saturation), and FILTER_LEN=1 (single-edge following). Directed
//   scenarios check constants; a randomized phase checks all instances against
//   a behavioural model that counts differing samples per channel.
module tb_multi_pulse_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clr_glitch;
    logic [3:0]  noisy_in;

    logic [3:0]  lvl_def, rise_def, fall_def;
    logic [31:0] g_def;
    logic [3:0]  lvl_c2, rise_c2, fall_c2;
    logic [7:0]  g_c2;
    logic [3:0]  lvl_f1, rise_f1, fall_f1;
    logic [31:0] g_f1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multi_pulse_filter u_dut (
        .clk(clk), .rst(rst), .en(en), .clr_glitch(clr_glitch), .noisy_in(noisy_in),
        .level_out(lvl_def), .rise_pulse(rise_def), .fall_pulse(fall_def), .glitch_cnt(g_def)
    );

    multi_pulse_filter #(.CHANNELS(4), .FILTER_LEN(3), .CNT_W(2)) u_dut_c2 (
        .clk(clk), .rst(rst), .en(en), .clr_glitch(clr_glitch), .noisy_in(noisy_in),
        .level_out(lvl_c2), .rise_pulse(rise_c2), .fall_pulse(fall_c2), .glitch_cnt(g_c2)
    );

    multi_pulse_filter #(.CHANNELS(4), .FILTER_LEN(1), .CNT_W(8)) u_dut_f1 (
        .clk(clk), .rst(rst), .en(en), .clr_glitch(clr_glitch), .noisy_in(noisy_in),
        .level_out(lvl_f1), .rise_pulse(rise_f1), .fall_pulse(fall_f1), .glitch_cnt(g_f1)
    );

    // Reference model: per config k, per channel c. streak = number of
    // consecutive enabled samples that disagree with the filtered level.
    int cfg_len[3]  = '{3, 3, 1};
    int cfg_gmax[3] = '{255, 3, 255};
    int m_lvl[3][4];
    int m_streak[3][4];
    int m_glt[3][4];
    int m_rise[3][4];
    int m_fall[3][4];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 4; c++) begin
                automatic int l = m_lvl[k][c];
                automatic int s = m_streak[k][c];
                automatic int g = m_glt[k][c];
                automatic int r = 0;
                automatic int f = 0;
                if (rst) begin
                    l = 0; s = 0; g = 0;
                end else begin
                    if (en) begin
                        if (int'(noisy_in[c]) != l) begin
                            s = s + 1;
                            if (s == cfg_len[k]) begin
                                l = 1 - l;
                                s = 0;
                                if (l == 1) r = 1; else f = 1;
                            end
                        end else if (s > 0) begin
                            s = 0;
                            g = (g < cfg_gmax[k]) ? g + 1 : g;
                        end
                    end
                    if (clr_glitch) g = 0;
                end
                m_lvl[k][c]    <= l;
                m_streak[k][c] <= s;
                m_glt[k][c]    <= g;
                m_rise[k][c]   <= r;
                m_fall[k][c]   <= f;
            end
        end
    end

    function automatic int dut_lvl(input int k, input int c);
        case (k)
            0:       return int'(lvl_def[c]);
            1:       return int'(lvl_c2[c]);
            default: return int'(lvl_f1[c]);
        endcase
    endfunction

    function automatic int dut_rise(input int k, input int c);
        case (k)
            0:       return int'(rise_def[c]);
            1:       return int'(rise_c2[c]);
            default: return int'(rise_f1[c]);
        endcase
    endfunction

    function automatic int dut_fall(input int k, input int c);
        case (k)
            0:       return int'(fall_def[c]);
            1:       return int'(fall_c2[c]);
            default: return int'(fall_f1[c]);
        endcase
    endfunction

    function automatic int dut_glt(input int k, input int c);
        case (k)
            0:       return int'(g_def[c*8 +: 8]);
            1:       return int'(g_c2[c*2 +: 2]);
            default: return int'(g_f1[c*8 +: 8]);
        endcase
    endfunction

    task automatic cyc(input logic r, input logic e, input logic cl, input logic [3:0] d);
        rst = r; en = e; clr_glitch = cl; noisy_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 4'h0);
        cyc(1'b1, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic test_reset();
        // rst must win over en/clr with every input differing
        cyc(1'b1, 1'b1, 1'b1, 4'hF);
        cyc(1'b1, 1'b1, 1'b0, 4'hF);
        n_vec++;
        if ({lvl_def, rise_def, fall_def} !== 12'h000) begin
            n_err++; $display("FAIL reset_def_outs got=%h exp=000", {lvl_def, rise_def, fall_def});
        end
        n_vec++;
        if ({lvl_f1, rise_f1, fall_f1} !== 12'h000) begin
            n_err++; $display("FAIL reset_f1_outs got=%h exp=000", {lvl_f1, rise_f1, fall_f1});
        end
        n_vec++;
        if ({g_def, g_c2, g_f1} !== 72'h0) begin
            n_err++; $display("FAIL reset_glitch got=%h %h %h exp=0", g_def, g_c2, g_f1);
        end
    endtask

    task automatic test_rise();
        do_reset();
        for (int e = 1; e <= 4; e++) begin
            cyc(1'b0, 1'b1, 1'b0, 4'b0001);
            n_vec++;
            if (lvl_def !== ((e >= 3) ? 4'b0001 : 4'b0000)) begin
                n_err++; $display("FAIL rise_level edge=%0d got=%b exp=%b", e, lvl_def,
                                  (e >= 3) ? 4'b0001 : 4'b0000);
            end
            n_vec++;
            if (rise_def !== ((e == 3) ? 4'b0001 : 4'b0000) || fall_def !== 4'b0000) begin
                n_err++; $display("FAIL rise_pulse edge=%0d got=%b/%b exp=%b/0000", e, rise_def,
                                  fall_def, (e == 3) ? 4'b0001 : 4'b0000);
            end
        end
    endtask

    task automatic test_glitch_abort();
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 4'b0010);
        cyc(1'b0, 1'b1, 1'b0, 4'b0010);
        cyc(1'b0, 1'b1, 1'b0, 4'b0000);
        n_vec++;
        if (lvl_def !== 4'b0000) begin
            n_err++; $display("FAIL abort_level got=%b exp=0000", lvl_def);
        end
        n_vec++;
        if (g_def[15:8] !== 8'd1) begin
            n_err++; $display("FAIL abort_glitch1 got=%0d exp=1", g_def[15:8]);
        end
    endtask

    task automatic test_enable_hold();
        do_reset();
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 4'b0100);
        n_vec++;
        if (lvl_def !== 4'b0100) begin
            n_err++; $display("FAIL hold_setup got=%b exp=0100", lvl_def);
        end
        cyc(1'b0, 1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
            n_vec++;
            if (lvl_def !== 4'b0100 || rise_def !== 4'b0 || fall_def !== 4'b0) begin
                n_err++; $display("FAIL hold_en0 i=%0d got=%b/%b/%b exp=0100/0000/0000", i,
                                  lvl_def, rise_def, fall_def);
            end
        end
        cyc(1'b0, 1'b1, 1'b0, 4'b0000);
        n_vec++;
        if (lvl_def !== 4'b0100 || fall_def !== 4'b0000) begin
            n_err++; $display("FAIL hold_resume1 got=%b/%b exp=0100/0000", lvl_def, fall_def);
        end
        cyc(1'b0, 1'b1, 1'b0, 4'b0000);
        n_vec++;
        if (lvl_def !== 4'b0000 || fall_def !== 4'b0100 || rise_def !== 4'b0000) begin
            n_err++; $display("FAIL hold_resume2 got=%b/%b/%b exp=0000/0100/0000", lvl_def,
                              fall_def, rise_def);
        end
        n_vec++;
        if (g_def[23:16] !== 8'd0) begin
            n_err++; $display("FAIL hold_glitch got=%0d exp=0", g_def[23:16]);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 4'b1000);
            cyc(1'b0, 1'b1, 1'b0, 4'b0000);
            n_vec++;
            if (g_c2[7:6] !== 2'((i > 3) ? 3 : i)) begin
                n_err++; $display("FAIL sat_c2 i=%0d got=%0d exp=%0d", i, g_c2[7:6], (i > 3) ? 3 : i);
            end
        end
        n_vec++;
        if (g_def[31:24] !== 8'd5) begin
            n_err++; $display("FAIL sat_def got=%0d exp=5", g_def[31:24]);
        end
        cyc(1'b0, 1'b1, 1'b0, 4'b1000);
        cyc(1'b0, 1'b1, 1'b1, 4'b0000);
        n_vec++;
        if (g_c2[7:6] !== 2'd0 || g_def[31:24] !== 8'd0) begin
            n_err++; $display("FAIL sat_clr got=%0d/%0d exp=0/0", g_c2[7:6], g_def[31:24]);
        end
    endtask

    task automatic test_len1();
        logic [3:0] d;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            d = (i % 2 == 0) ? 4'hF : 4'h0;
            cyc(1'b0, 1'b1, 1'b0, d);
            n_vec++;
            if (lvl_f1 !== d || rise_f1 !== d || fall_f1 !== ~d) begin
                n_err++; $display("FAIL len1 i=%0d got=%b/%b/%b exp=%b/%b/%b", i, lvl_f1, rise_f1,
                                  fall_f1, d, d, ~d);
            end
        end
        n_vec++;
        if (g_f1 !== 32'd0) begin
            n_err++; $display("FAIL len1_glitch got=%h exp=0", g_f1);
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 4'b0001);
        cyc(1'b0, 1'b1, 1'b0, 4'b0001);
        cyc(1'b1, 1'b1, 1'b0, 4'b0001);
        n_vec++;
        if ({lvl_def, rise_def, fall_def, g_def} !== 44'h0) begin
            n_err++; $display("FAIL midrun_rst got=%b/%b/%b/%h exp=0", lvl_def, rise_def, fall_def, g_def);
        end
        for (int e = 1; e <= 3; e++) begin
            cyc(1'b0, 1'b1, 1'b0, 4'b0001);
            n_vec++;
            if (rise_def !== ((e == 3) ? 4'b0001 : 4'b0000)) begin
                n_err++; $display("FAIL midrun_rise edge=%0d got=%b exp=%b", e, rise_def,
                                  (e == 3) ? 4'b0001 : 4'b0000);
            end
        end
        n_vec++;
        if (g_def !== 32'd0) begin
            n_err++; $display("FAIL midrun_glitch got=%h exp=0", g_def);
        end
    endtask

    task automatic test_random();
        logic [3:0] d = 4'h0;
        do_reset();
        for (int t = 0; t < 800; t++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 2) == 0) d[c] = ~d[c];
            end
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 39) == 0), d);
            for (int k = 0; k < 3; k++) begin
                for (int c = 0; c < 4; c++) begin
                    n_vec++;
                    if (dut_lvl(k, c) !== m_lvl[k][c] || dut_rise(k, c) !== m_rise[k][c] ||
                        dut_fall(k, c) !== m_fall[k][c] || dut_glt(k, c) !== m_glt[k][c]) begin
                        n_err++;
                        $display("FAIL random t=%0d cfg=%0d ch=%0d got lvl/r/f/g=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d",
                                 t, k, c, dut_lvl(k, c), dut_rise(k, c), dut_fall(k, c), dut_glt(k, c),
                                 m_lvl[k][c], m_rise[k][c], m_fall[k][c], m_glt[k][c]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr_glitch = 1'b0; noisy_in = 4'h0;
        test_reset();
        test_rise();
        test_glitch_abort();
        test_enable_hold();
        test_saturate();
        test_len1();
        test_reset_midrun();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
